axis_frame_arbiter: RTL and testbench

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

---
 rtl/axis_frame_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: S_COUNT-to-1 AXI4-Stream arbiter with frame-granular grants.
//
// An input is granted one cycle after it raises tvalid while the arbiter is
// idle, keeps the grant for its whole frame (up to and including the tlast
// beat), and the arbiter then idles for one cycle before the next decision.
// The granted input is wired combinationally to the output, so backpressure
// is lossless and adds no latency.
//
// Build option:
//   AXIS_FRAME_ARBITER_RR_EN  defined   -> round-robin; the search starts after
//                                          the input whose frame last completed.
//                             undefined -> fixed priority, lowest index wins,
//                                          and no pointer register exists.
module axis_frame_arbiter #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH  = 1,
  parameter int LAST_ENABLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  output logic [S_COUNT-1:0]            s_axis_tready,

  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(S_COUNT)-1:0]    m_axis_tid,

  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index
);

  localparam int IDX_W = $clog2(S_COUNT);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_index_q, grant_index_d;

  // Arbitration result for the current idle cycle.
  logic               req_any;
  logic [IDX_W-1:0]   req_index;
  logic [IDX_W-1:0]   cand_index;

  // A beat that closes the granted frame.
  logic               frame_done;

`ifdef AXIS_FRAME_ARBITER_RR_EN
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W:0]     cand;
`endif

  // Per-input views of the packed sideband buses.
  logic [DATA_WIDTH-1:0] in_tdata [S_COUNT];
  logic [KEEP_WIDTH-1:0] in_tkeep [S_COUNT];
  logic [USER_WIDTH-1:0] in_tuser [S_COUNT];

  for (genvar i = 0; i < S_COUNT; i++) begin : g_unpack
    assign in_tdata[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign in_tkeep[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    assign in_tuser[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  assign grant_valid = (state_q == ST_ACTIVE);
  assign grant_index = grant_index_q;

  // Winner selection: first requesting input found from the search start.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    req_any    = 1'b0;
    req_index  = '0;
    cand_index = '0;
`ifdef AXIS_FRAME_ARBITER_RR_EN
    cand       = '0;
`endif
    for (int i = 0; i < S_COUNT; i++) begin
`ifdef AXIS_FRAME_ARBITER_RR_EN
      // Rotate the search so it starts at the pointer and wraps at S_COUNT.
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(S_COUNT)) begin
        cand = cand - (IDX_W+1)'(S_COUNT);
      end
      cand_index = cand[IDX_W-1:0];
`else
      cand_index = IDX_W'(i);
`endif
      if (!req_any && s_axis_tvalid[cand_index]) begin
        req_any   = 1'b1;
        req_index = cand_index;
      end
    end
  end

  // Output datapath: granted input straight through, everything quiet in IDLE.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tid    = '0;
    s_axis_tready = '0;
    if (state_q == ST_ACTIVE) begin
      m_axis_tdata  = in_tdata[grant_index_q];
      m_axis_tkeep  = in_tkeep[grant_index_q];
      m_axis_tuser  = in_tuser[grant_index_q];
      m_axis_tvalid = s_axis_tvalid[grant_index_q];
      m_axis_tid    = grant_index_q;
      // Without framing every beat stands alone, so it is always a last beat.
      m_axis_tlast  = (LAST_ENABLE != 0) ? s_axis_tlast[grant_index_q] : 1'b1;
      s_axis_tready[grant_index_q] = m_axis_tready;
    end
  end

  assign frame_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // FSM next state: grant on any request in IDLE, release on the frame's last beat.
  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d       = ST_ACTIVE;
          grant_index_d = req_index;
        end
      end
      ST_ACTIVE: begin
        if (frame_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef AXIS_FRAME_ARBITER_RR_EN
  // Pointer advances past the input whose frame just finished, never mid-frame.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (frame_done) begin
      rr_ptr_d = (grant_index_q == IDX_W'(S_COUNT - 1)) ? '0
                                                         : grant_index_q + 1'b1;
    end
  end
`endif

  // State registers with synchronous reset; a reset mid-frame drops the grant.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_index_q <= '0;
`ifdef AXIS_FRAME_ARBITER_RR_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
`ifdef AXIS_FRAME_ARBITER_RR_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter: directed stimulus with a scoreboard for
// axis_frame_arbiter. Per-input source queues drive the slave ports, expected
// output beats are queued when stimulus is issued, and a monitor pops and
// compares every output handshake. A second instance covers LAST_ENABLE=0.
`timescale 1ns/1ps
module tb_axis_frame_arbiter;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT signals.
  logic [S*DW-1:0] s_tdata  = '0;
  logic [S-1:0]    s_tkeep  = '1;
  logic [S-1:0]    s_tuser  = '0;
  logic [S-1:0]    s_tvalid = '0;
  logic [S-1:0]    s_tlast  = '0;
  logic [S-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [0:0]      m_tkeep;
  logic [0:0]      m_tuser;
  logic            m_tlast, m_tvalid;
  logic            m_tready = 1'b1;
  logic [IW-1:0]   m_tid, grant_index;
  logic            grant_valid;

  axis_frame_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(1), .USER_WIDTH(1), .LAST_ENABLE(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tid(m_tid), .grant_valid(grant_valid), .grant_index(grant_index)
  );

  // Unframed instance.
  logic [15:0] nl_s_tdata  = '0;
  logic [1:0]  nl_s_tkeep  = '1;
  logic [1:0]  nl_s_tuser  = '0;
  logic [1:0]  nl_s_tvalid = '0;
  logic [1:0]  nl_s_tlast  = '0;
  logic [1:0]  nl_s_tready;
  logic [7:0]  nl_m_tdata;
  logic [0:0]  nl_m_tkeep, nl_m_tuser, nl_m_tid, nl_grant_index;
  logic        nl_m_tlast, nl_m_tvalid, nl_grant_valid;
  logic        nl_m_tready = 1'b1;

  axis_frame_arbiter #(
    .S_COUNT(2), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1), .LAST_ENABLE(0)
  ) u_dut_nl (
    .clk(clk), .rst(rst),
    .s_axis_tdata(nl_s_tdata), .s_axis_tkeep(nl_s_tkeep), .s_axis_tuser(nl_s_tuser),
    .s_axis_tvalid(nl_s_tvalid), .s_axis_tlast(nl_s_tlast), .s_axis_tready(nl_s_tready),
    .m_axis_tdata(nl_m_tdata), .m_axis_tkeep(nl_m_tkeep), .m_axis_tuser(nl_m_tuser),
    .m_axis_tlast(nl_m_tlast), .m_axis_tvalid(nl_m_tvalid), .m_axis_tready(nl_m_tready),
    .m_axis_tid(nl_m_tid), .grant_valid(nl_grant_valid), .grant_index(nl_grant_index)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream source model: one beat queue per input.
  typedef struct packed {logic [7:0] data; logic last;} sbeat_t;
  sbeat_t src_q [S][$];
  logic [S-1:0] fire = '0;

  task automatic src_push(input int src, input logic [7:0] d, input logic last);
    sbeat_t b;
    b.data = d;
    b.last = last;
    src_q[src].push_back(b);
  endtask

  // Handshakes are sampled mid-cycle, where inputs and DUT outputs are settled.
  always @(negedge clk) fire = s_tvalid & s_tready;

  // Retire accepted beats and present the next one just after each edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < S; i++) begin
      if (fire[i] && src_q[i].size() > 0) src_q[i].delete(0);
      if (src_q[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*DW +: DW] = src_q[i][0].data;
        s_tlast[i]          = src_q[i][0].last;
        s_tuser[i]          = src_q[i][0].data[0];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]          = 1'b0;
        s_tuser[i]          = 1'b0;
      end
    end
  end

  // Scoreboard of expected output beats (keep is always 1, user is data bit 0).
  typedef struct packed {logic [1:0] tid; logic [7:0] data; logic last;} ebeat_t;
  ebeat_t exp_q[$];
  ebeat_t e;

  task automatic expect_beat(input int tid, input logic [7:0] d, input logic last);
    ebeat_t x;
    x.tid  = 2'(tid);
    x.data = d;
    x.last = last;
    exp_q.push_back(x);
  endtask

  bit mon_en        = 1'b0;
  bit gap_chk       = 1'b0;
  bit prev_fire_ok  = 1'b0;
  bit prev_last     = 1'b0;
  bit chk_idle_next = 1'b0;
  int cyc           = 0;
  int last_fire_cyc = 0;

  // Monitor for the main DUT.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (chk_idle_next) begin
        check("idle_after_frame", 32'(grant_valid), 32'd0);
        chk_idle_next = 1'b0;
      end
      if (!grant_valid) check("idle_outputs", 32'({m_tvalid, s_tready, m_tid}), 32'd0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got tid %0d data 0x%0h expected no beat at %0t",
                   m_tid, m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({m_tid, m_tdata, m_tlast, m_tkeep, m_tuser}),
                32'({e.tid, e.data, e.last, 1'b1, e.data[0]}));
        end
        if (gap_chk && prev_fire_ok && prev_last)
          check("frame_gap", 32'(cyc - last_fire_cyc), 32'd2);
        prev_fire_ok  = gap_chk;
        prev_last     = m_tlast;
        last_fire_cyc = cyc;
        if (m_tlast) chk_idle_next = 1'b1;
      end
    end
  end

  // Monitor for the unframed instance.
  logic [7:0] exp2_q[$];
  logic [7:0] e2;
  int  nl_grants = 0;
  bit  nl_gv_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (nl_m_tvalid && nl_m_tready) begin
        if (exp2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL nl_unexpected_beat: got data 0x%0h expected no beat", nl_m_tdata);
        end else begin
          e2 = exp2_q.pop_front();
          check("nl_beat", 32'({nl_m_tid, nl_m_tdata, nl_m_tlast}), 32'({1'b0, e2, 1'b1}));
        end
      end
      if (nl_grant_valid && !nl_gv_prev) nl_grants++;
      nl_gv_prev = nl_grant_valid;
    end
  end

  task automatic wait_grant(input int idx, input int limit);
    int n = 0;
    @(negedge clk);
    while (!(grant_valid && grant_index == IW'(idx)) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("grant_wait", 32'({grant_valid, grant_index}), 32'({1'b1, IW'(idx)}));
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic nl_wait_hs(input int limit);
    int n = 0;
    @(negedge clk);
    while (!(nl_s_tvalid[0] && nl_s_tready[0]) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("nl_handshake", 32'(nl_s_tready[0]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_index", 32'(grant_index), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tid", 32'(m_tid), 32'd0);
    mon_en = 1'b1;

    // Single 3-beat frame from input 2; one decision cycle, then the beats.
    src_push(2, 8'hA1, 1'b0); expect_beat(2, 8'hA1, 1'b0);
    src_push(2, 8'hA2, 1'b0); expect_beat(2, 8'hA2, 1'b0);
    src_push(2, 8'hA3, 1'b1); expect_beat(2, 8'hA3, 1'b1);
    @(negedge clk);
    check("t1_decision_cycle", 32'({grant_valid, m_tvalid}), 32'd0);
    @(negedge clk);
    check("t1_grant", 32'({grant_valid, grant_index, m_tid}), 32'({1'b1, 2'd2, 2'd2}));
    drain(20);

    // Contention between continuously offering inputs.
    pulse_reset();
    @(negedge clk);
    gap_chk = 1'b1;
`ifdef AXIS_FRAME_ARBITER_RR_EN
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < S; i++) begin
        src_push(i, 8'(8'h40 + 16 * i + r), 1'b1);
        expect_beat(i, 8'(8'h40 + 16 * i + r), 1'b1);
      end
    end
`else
    src_push(3, 8'h71, 1'b1);
    for (int r = 0; r < 3; r++) begin
      src_push(1, 8'(8'h51 + r), 1'b1);
      expect_beat(1, 8'(8'h51 + r), 1'b1);
    end
    expect_beat(3, 8'h71, 1'b1);
`endif
    drain(60);
    gap_chk = 1'b0;

    // Backpressure mid-frame while another input starts requesting.
    src_push(0, 8'hB1, 1'b0); expect_beat(0, 8'hB1, 1'b0);
    src_push(0, 8'hB2, 1'b0); expect_beat(0, 8'hB2, 1'b0);
    src_push(0, 8'hB3, 1'b1); expect_beat(0, 8'hB3, 1'b1);
    expect_beat(1, 8'hC1, 1'b1);
    wait_grant(0, 10);
    @(posedge clk); #1 m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) src_push(1, 8'hC1, 1'b1);
      check("stall_data", 32'({m_tvalid, m_tdata, m_tid, grant_index}),
            32'({1'b1, 8'hB2, 2'd0, 2'd0}));
      check("stall_tready", 32'(s_tready), 32'd0);
    end
    @(posedge clk); #1 m_tready = 1'b1;
    drain(30);

    // Reset during beat 2 of a 4-beat frame from input 1.
    src_push(1, 8'hD1, 1'b0); expect_beat(1, 8'hD1, 1'b0);
    src_push(1, 8'hD2, 1'b0); expect_beat(1, 8'hD2, 1'b0);
    src_push(1, 8'hD3, 1'b0); expect_beat(1, 8'hD3, 1'b0);
    src_push(1, 8'hD4, 1'b1); expect_beat(1, 8'hD4, 1'b1);
    wait_grant(1, 10);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_quiet", 32'({grant_valid, m_tvalid, s_tready}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_decision", 32'(grant_valid), 32'd0);
    @(negedge clk);
    check("midrst_regrant", 32'({grant_valid, grant_index, m_tdata}),
          32'({1'b1, 2'd1, 8'hD3}));
    drain(20);

    // Unframed instance: each beat is its own grant, tlast forced high.
    base = nl_grants;
    exp2_q.push_back(8'h10);
    exp2_q.push_back(8'h11);
    @(posedge clk); #1;
    nl_s_tvalid[0]   = 1'b1;
    nl_s_tdata[7:0]  = 8'h10;
    nl_s_tlast[0]    = 1'b0;
    nl_wait_hs(10);
    @(posedge clk); #1 nl_s_tdata[7:0] = 8'h11;
    @(negedge clk);
    check("nl_idle_between", 32'(nl_grant_valid), 32'd0);
    nl_wait_hs(10);
    @(posedge clk); #1 nl_s_tvalid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("nl_grant_count", 32'(nl_grants - base), 32'd2);
    check("nl_drain", 32'(exp2_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
